// File: rtl/tank_pkg.sv
// Shared playfield geometry, cell grid limits and the obstacle placer FSM state type.
package tank_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int CELL_SIZE = 8;
  localparam int TANK_SIZE = 16;

  // Legal obstacle cell range: keeps a 4-cell border clear on every side.
  localparam int CELL_X_MIN = 4;
  localparam int CELL_X_MAX = 75;
  localparam int CELL_Y_MIN = 4;
  localparam int CELL_Y_MAX = 55;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SCAN,
    COMMIT,
    DONE
  } placer_state_t;

  // Magnitude of an 11-bit two's complement value.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic [10:0] r;
    r = v;
    if (v[10]) r = ~r + 11'd1;
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
module lfsr16 #(
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic        en,
  output logic [15:0] out
);

  // Load the seed on reset, otherwise step once per enabled cycle.
  always_ff @(posedge Clk) begin
    if (Reset_h)
      out <= seed;
    else if (en)
      out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
  end

endmodule

// File: rtl/obstacle_placer.sv
// Fills NUM_OBST obstacle slots with pseudo-random cell-aligned positions,
// keeping clear of both tank spawn points and of previously placed obstacles.
module obstacle_placer
  import tank_pkg::*;
#(
  parameter int          NUM_OBST  = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64,
  parameter int          EXCL      = 32
) (
  input  logic                     Clk,
  input  logic                     Reset_h,
  input  logic                     start,
  input  logic [9:0]               Tank1X,
  input  logic [9:0]               Tank1Y,
  input  logic [9:0]               Tank2X,
  input  logic [9:0]               Tank2Y,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_OBST*10-1:0]   obst_x_flat,
  output logic [NUM_OBST*10-1:0]   obst_y_flat,
  output logic [NUM_OBST-1:0]      obst_valid
);

  localparam int IW = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_OBST - 1);
  localparam logic [TW-1:0] LAST_TRY  = TW'(MAX_TRIES - 1);

  placer_state_t state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  k;
  logic [TW-1:0]  tries;
  logic [6:0]     cand_cx;
  logic [5:0]     cand_cy;
  logic [6:0]     cx_mem [NUM_OBST];
  logic [5:0]     cy_mem [NUM_OBST];

  logic [15:0]    lfsr_q;
  logic           lfsr_en;
  logic           lfsr_unused;

  logic [6:0]     gen_cx;
  logic [5:0]     gen_cy;
  logic [9:0]     gen_x;
  logic [9:0]     gen_y;
  logic           gen_reject;
  logic           scan_hit;
  logic           give_up;
  logic           slot_end;

  assign lfsr_en = (state == GEN);

  lfsr16 #(.seed(SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_h (Reset_h),
    .en      (lfsr_en),
    .out     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:13];

  // True when candidate (x,y) centre lies inside the square exclusion zone of a tank.
  function automatic logic tank_hit(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] tx, input logic [9:0] ty);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    dx = $signed({1'b0, x}) + 11'sd4 - $signed({1'b0, tx});
    dy = $signed({1'b0, y}) + 11'sd4 - $signed({1'b0, ty});
    return (int'(abs11(dx)) < EXCL) && (int'(abs11(dy)) < EXCL);
  endfunction

  function automatic logic close7(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d < 7'd2;
  endfunction

  function automatic logic close6(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d < 6'd2;
  endfunction

  // Candidate cell from the current LFSR value and its rejection conditions.
  always_comb begin
    gen_cx     = lfsr_q[6:0];
    gen_cy     = lfsr_q[12:7];
    gen_x      = {gen_cx, 3'b000};
    gen_y      = {1'b0, gen_cy, 3'b000};
    gen_reject = (gen_cx < 7'(CELL_X_MIN)) || (gen_cx > 7'(CELL_X_MAX)) ||
                 (gen_cy < 6'(CELL_Y_MIN)) || (gen_cy > 6'(CELL_Y_MAX)) ||
                 tank_hit(gen_x, gen_y, Tank1X, Tank1Y) ||
                 tank_hit(gen_x, gen_y, Tank2X, Tank2Y);
    scan_hit   = obst_valid[k] && close7(cand_cx, cx_mem[k]) && close6(cand_cy, cy_mem[k]);
    // A rejection on the final allowed try ends the slot, whether it came from GEN or SCAN.
    give_up    = (tries == LAST_TRY) &&
                 (((state == GEN) && gen_reject) || ((state == SCAN) && scan_hit));
    slot_end   = give_up || (state == COMMIT);
  end

  // Main FSM: slot writes, try/slot counters and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state      <= IDLE;
      idx        <= '0;
      k          <= '0;
      tries      <= '0;
      cand_cx    <= '0;
      cand_cy    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      obst_valid <= '0;
      for (int unsigned s = 0; s < NUM_OBST; s++) begin
        cx_mem[s] <= '0;
        cy_mem[s] <= '0;
      end
    end else if (slot_end) begin
      // Commit and give-up share the slot write and the advance to the next slot.
      cx_mem[idx]     <= give_up ? 7'd0 : cand_cx;
      cy_mem[idx]     <= give_up ? 6'd0 : cand_cy;
      obst_valid[idx] <= !give_up;
      tries           <= '0;
      if (idx == LAST_SLOT) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        idx   <= idx + IW'(1);
        state <= GEN;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            k          <= '0;
            tries      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            obst_valid <= '0;
            for (int unsigned s = 0; s < NUM_OBST; s++) begin
              cx_mem[s] <= '0;
              cy_mem[s] <= '0;
            end
            state <= GEN;
          end
        end
        GEN: begin
          if (gen_reject) begin
            tries <= tries + TW'(1);
          end else begin
            cand_cx <= gen_cx;
            cand_cy <= gen_cy;
            k       <= '0;
            state   <= (idx != '0) ? SCAN : COMMIT;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            tries <= tries + TW'(1);
            state <= GEN;
          end else if (k == idx - IW'(1)) begin
            state <= COMMIT;
          end else begin
            k <= k + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expand stored cells to pixel coordinates on the flat output buses.
  always_comb begin
    obst_x_flat = '0;
    obst_y_flat = '0;
    for (int unsigned s = 0; s < NUM_OBST; s++) begin
      obst_x_flat[10*s +: 10] = {cx_mem[s], 3'b000};
      obst_y_flat[10*s +: 10] = {1'b0, cy_mem[s], 3'b000};
    end
  end

endmodule

// File: tb/tb_obstacle_placer.sv
// Directed bench for obstacle_placer: reset, timing, table contents, restart and abort.
module tb_obstacle_placer;

  localparam int N  = 8;
  localparam int N2 = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clk = 1'b0;
  logic Reset_h;
  logic start;
  logic [9:0] tank1x, tank1y, tank2x, tank2y;

  logic busy, done;
  logic [N*10-1:0] ox, oy;
  logic [N-1:0] ov;
  logic busy2, done2;
  logic [N2*10-1:0] ox2, oy2;
  logic [N2-1:0] ov2;

  always #5 Clk = ~Clk;

  obstacle_placer #(.NUM_OBST(N), .SEED(SEED), .MAX_TRIES(64), .EXCL(32)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .start(start),
    .Tank1X(tank1x), .Tank1Y(tank1y), .Tank2X(tank2x), .Tank2Y(tank2y),
    .busy(busy), .done(done),
    .obst_x_flat(ox), .obst_y_flat(oy), .obst_valid(ov)
  );

  // Exclusion covers the whole field, so every candidate is rejected.
  obstacle_placer #(.NUM_OBST(N2), .SEED(SEED), .MAX_TRIES(64), .EXCL(1024)) dut_gu (
    .Clk(Clk), .Reset_h(Reset_h), .start(start),
    .Tank1X(tank1x), .Tank1Y(tank1y), .Tank2X(tank2x), .Tank2Y(tank2y),
    .busy(busy2), .done(done2),
    .obst_x_flat(ox2), .obst_y_flat(oy2), .obst_valid(ov2)
  );

  int nvec  = 0;
  int nfail = 0;

  logic [15:0] m_lfsr;
  int m_cx [N];
  int m_cy [N];
  bit m_v  [N];
  int m_cycles;

  logic [N*10-1:0] ax, ay;
  logic [N-1:0] av;
  int a_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit near_tank(input int x, input int y, input int tx, input int ty);
    int dx, dy;
    dx = x + 4 - tx;
    dy = y + 4 - ty;
    return (dx < 32) && (dx > -32) && (dy < 32) && (dy > -32);
  endfunction

  // Untimed reference of the placement algorithm, including its cycle cost.
  task automatic model_run(input int t1x, input int t1y, input int t2x, input int t2y);
    int tries, cx, cy, dcx, dcy;
    bit rej, placed, gave;
    m_cycles = 0;
    for (int s = 0; s < N; s++) begin
      m_cx[s] = 0; m_cy[s] = 0; m_v[s] = 0;
    end
    for (int s = 0; s < N; s++) begin
      tries = 0; placed = 0; gave = 0;
      while (!placed && !gave) begin
        cx = int'(m_lfsr[6:0]);
        cy = int'(m_lfsr[12:7]);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_cycles++;
        rej = (cx < 4) || (cx > 75) || (cy < 4) || (cy > 55) ||
              near_tank(cx * 8, cy * 8, t1x, t1y) || near_tank(cx * 8, cy * 8, t2x, t2y);
        if (!rej) begin
          for (int q = 0; q < s; q++) begin
            m_cycles++;
            dcx = cx - m_cx[q];
            dcy = cy - m_cy[q];
            if (m_v[q] && dcx < 2 && dcx > -2 && dcy < 2 && dcy > -2) begin
              rej = 1;
              break;
            end
          end
        end
        if (rej) begin
          tries++;
          if (tries == 64) gave = 1;
        end else begin
          m_cycles++;
          m_cx[s] = cx; m_cy[s] = cy; m_v[s] = 1;
          placed = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    Reset_h = 1'b1;
    start   = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset_h = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Cycles after the call at which each instance first shows done (-1 if never).
  task automatic wait_both(output int n1, output int n2);
    n1 = -1; n2 = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge Clk); #1;
      if (done && n1 < 0) n1 = c;
      if (done2 && n2 < 0) n2 = c;
      if (n1 >= 0 && n2 >= 0) break;
    end
  endtask

  task automatic check_model(input string tag);
    for (int s = 0; s < N; s++) begin
      check({tag, "_x"}, 32'(ox[10*s +: 10]), 32'(m_cx[s] * 8));
      check({tag, "_y"}, 32'(oy[10*s +: 10]), 32'(m_cy[s] * 8));
      check({tag, "_v"}, 32'(ov[s]), 32'(m_v[s]));
    end
  endtask

  task automatic check_props(input string tag);
    int x, y, xq, yq;
    bit bad_grid, bad_range, bad_tank, bad_space;
    bad_grid = 0; bad_range = 0; bad_tank = 0; bad_space = 0;
    for (int s = 0; s < N; s++) begin
      if (ov[s]) begin
        x = int'(ox[10*s +: 10]);
        y = int'(oy[10*s +: 10]);
        if ((x % 8) != 0 || (y % 8) != 0) bad_grid = 1;
        if (x < 32 || x > 600 || y < 32 || y > 440) bad_range = 1;
        if (near_tank(x, y, int'(tank1x), int'(tank1y)) ||
            near_tank(x, y, int'(tank2x), int'(tank2y))) bad_tank = 1;
        for (int q = 0; q < s; q++) begin
          if (ov[q]) begin
            xq = int'(ox[10*q +: 10]);
            yq = int'(oy[10*q +: 10]);
            if (x - xq < 16 && xq - x < 16 && y - yq < 16 && yq - y < 16) bad_space = 1;
          end
        end
      end
    end
    check({tag, "_grid"}, 32'(bad_grid), 0);
    check({tag, "_range"}, 32'(bad_range), 0);
    check({tag, "_tank"}, 32'(bad_tank), 0);
    check({tag, "_spacing"}, 32'(bad_space), 0);
  endtask

  initial begin
    int n1, n2;
    tank1x = 10'd0; tank1y = 10'd0; tank2x = 10'd0; tank2y = 10'd0;
    Reset_h = 1'b1;
    start   = 1'b0;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(ov), 0);
    check("rst_xzero", 32'(ox == '0), 1);
    check("rst_yzero", 32'(oy == '0), 1);
    check("rst_gu_busy", 32'(busy2), 0);

    // Run A: tanks at origin
    m_lfsr = SEED;
    model_run(0, 0, 0, 0);
    pulse_start();
    check("a_busy_next", 32'(busy), 1);
    check("a_done_low", 32'(done), 0);
    wait_both(n1, n2);
    check("a_cycles", 32'(n1), 32'(m_cycles));
    check("a_cycles_min", 32'(n1 >= 44), 1);
    check("a_busy_after", 32'(busy), 0);
    check("a_all_valid", 32'(ov), 32'hFF);
    check("a_slot0_x", 32'(ox[9:0]), 536);
    check("a_slot0_y", 32'(oy[9:0]), 408);
    check_model("a");
    check_props("a");
    check("gu_cycles", 32'(n2), 128);
    check("gu_valid", 32'(ov2), 0);
    check("gu_xzero", 32'(ox2 == '0), 1);
    check("gu_yzero", 32'(oy2 == '0), 1);
    check("gu_busy", 32'(busy2), 0);
    ax = ox; ay = oy; av = ov; a_cycles = n1;

    // Start in DONE: clear then regenerate from the current LFSR state
    model_run(0, 0, 0, 0);
    pulse_start();
    check("b_clear_valid", 32'(ov), 0);
    check("b_clear_x", 32'(ox == '0), 1);
    check("b_done_low", 32'(done), 0);
    check("b_busy", 32'(busy), 1);
    wait_both(n1, n2);
    check("b_cycles", 32'(n1), 32'(m_cycles));
    check_model("b");
    check_props("b");

    // Reset ten cycles into a run aborts; a later start reproduces run A
    do_reset();
    pulse_start();
    repeat (9) begin @(posedge Clk); #1; end
    check("c_busy_pre", 32'(busy), 1);
    Reset_h = 1'b1;
    @(posedge Clk); #1;
    check("c_busy", 32'(busy), 0);
    check("c_done", 32'(done), 0);
    check("c_valid", 32'(ov), 0);
    check("c_xzero", 32'(ox == '0), 1);
    check("c_yzero", 32'(oy == '0), 1);
    Reset_h = 1'b0;
    @(posedge Clk); #1;
    check("c_idle_busy", 32'(busy), 0);
    pulse_start();
    wait_both(n1, n2);
    check("c_cycles", 32'(n1), 32'(a_cycles));
    check("c_same_x", 32'(ox == ax), 1);
    check("c_same_y", 32'(oy == ay), 1);
    check("c_same_v", 32'(ov == av), 1);

    // start while busy is ignored
    do_reset();
    pulse_start();
    repeat (4) begin @(posedge Clk); #1; end
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check("d_busy_mid", 32'(busy), 1);
    wait_both(n1, n2);
    check("d_cycles", 32'(n1 + 5), 32'(a_cycles));
    check("d_same_x", 32'(ox == ax), 1);
    check("d_same_y", 32'(oy == ay), 1);
    check("d_same_v", 32'(ov == av), 1);

    // Tank1 at screen centre
    tank1x = 10'd320; tank1y = 10'd240;
    do_reset();
    m_lfsr = SEED;
    model_run(320, 240, 0, 0);
    pulse_start();
    wait_both(n1, n2);
    check("e_cycles", 32'(n1), 32'(m_cycles));
    check_model("e");
    check_props("e");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/obstacle_placer.md
OBSTACLE_PLACER -- requirements
Module: obstacle_placer

Interface
REQ-001 SHALL have parameter NUM_OBST, default 8, number of obstacle slots to fill (1..16).
REQ-002 SHALL have parameter SEED, default 16'hACE1, LFSR load value; must be nonzero.
REQ-003 SHALL have parameter MAX_TRIES, default 64, candidate attempts per slot before giving up.
REQ-004 SHALL have parameter EXCL, default 32, tank exclusion half-distance in pixels.
REQ-005 SHALL have port Clk, input, 1, the single clock; every register uses its rising edge.
REQ-006 SHALL have port Reset_h, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to regenerate the whole table.
REQ-008 SHALL have ports Tank1X, Tank1Y, Tank2X, Tank2Y, input, 10 each, tank spawn centres.
REQ-009 SHALL have port busy, output, 1, high while generating.
REQ-010 SHALL have port done, output, 1, high while the table is complete and stable.
REQ-011 SHALL have ports obst_x_flat and obst_y_flat, output, NUM_OBST*10 each; slot k occupies bits [10k+9:10k]; each pair drives one obstacle's x_init/y_init.
REQ-012 SHALL have port obst_valid, output, NUM_OBST, bit k high when slot k holds a placed position.

Function
REQ-013 SHALL implement FSM states IDLE, GEN, SCAN, COMMIT and DONE.
REQ-014 SHALL, on start sampled high in IDLE or DONE, clear all slots and obst_valid, set slot index i=0 and tries=0, drop done, and enter GEN; start in GEN, SCAN or COMMIT SHALL be ignored.
REQ-015 In GEN, the block SHALL form the candidate cell cx=lfsr[6:0], cy=lfsr[12:7]; set x=8*cx and y=8*cy; and advance the LFSR once.
REQ-016 In GEN, the candidate SHALL be rejected if cx<4 or cx>75, or if cy<4 or cy>55.
REQ-017 In GEN, the candidate SHALL be rejected if, for either tank, |x+4-TankX|<EXCL and |y+4-TankY|<EXCL; differences SHALL be computed 11-bit signed.
REQ-018 On rejection, tries SHALL increment and the FSM SHALL stay in GEN.
REQ-019 When tries reaches MAX_TRIES, slot i SHALL be written (0,0) with obst_valid[i]=0 and i SHALL advance.
REQ-020 An accepted candidate SHALL be latched and the FSM SHALL go to SCAN if i>0, else to COMMIT.
REQ-021 SCAN SHALL compare one prior valid slot k per cycle, k=0..i-1, and SHALL reject (return to GEN, tries+1) if |cx-cxk|<2 and |cy-cyk|<2; invalid prior slots SHALL be skipped, still one cycle each.
REQ-022 SCAN completing with no conflict SHALL enter COMMIT.
REQ-023 COMMIT SHALL write slot i, set obst_valid[i]=1, set tries=0 and increment i; it SHALL enter DONE when i was NUM_OBST-1, else GEN.
REQ-024 With no rejections, slot i SHALL cost 2+i cycles, so done SHALL rise exactly NUM_OBST*2+NUM_OBST*(NUM_OBST-1)/2 cycles after the start edge (44 cycles for 8 slots).
REQ-025 busy SHALL be high in GEN, SCAN and COMMIT; done SHALL be high only in DONE.
REQ-026 Outputs SHALL change only in COMMIT, in the give-up write, or in the start clear.
REQ-027 Tank inputs SHALL be sampled live each GEN cycle.
REQ-028 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11, advancing only in GEN.

Reset
REQ-029 Reset_h SHALL force state IDLE, i=0, tries=0, LFSR=SEED, all slots (0,0), obst_valid=0, busy=0 and done=0.
REQ-030 Reset_h mid-generation SHALL abort immediately with the same values; it SHALL take priority over start.

Structure
REQ-031 Playfield limits, cell size 8, TANK_SIZE and the FSM state enum SHALL live in shared package tank_pkg.
REQ-032 The LFSR SHALL be a sub-module lfsr16 with ports Clk, Reset_h, en and out[15:0], and parameter seed.

Verification
REQ-033 Reset, then start pulse, tanks at (0,0) and (0,0) -> busy next cycle; done after ≥44 cycles; all obst_valid=1; all coordinates multiples of 8 within x 32..600, y 32..440.
REQ-034 Tank1 at (320,240) -> no valid slot with |x+4-320|<32 and |y+4-240|<32.
REQ-035 Any completed run -> no two valid slots within one cell of each other in both axes.
REQ-036 Force the LFSR output constant out of range (seed chosen or bound by force) -> each slot gives up after 64 GEN cycles with (0,0) and valid=0; done still asserts.
REQ-037 Reset_h at cycle 10 of generation -> next cycle IDLE, outputs zero, busy=0; a later start with the same SEED reproduces the identical table.
REQ-038 start while busy -> ignored, with identical table and timing; start in DONE -> table cleared and regenerated from the current LFSR state.
